// File: rtl/if_fetch_stage_pkg.sv
// rtl/if_fetch_stage_pkg.sv - shared types and constants for the instruction-fetch stage
package if_fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [31:0] PC_INCR    = 32'd4;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/if_fetch_stage_if.sv
// rtl/if_fetch_stage_if.sv - instruction-memory request/ready handshake bundle
interface if_fetch_stage_if #(
  parameter int N = 32
);
  logic         imem_req_out;
  logic [N-1:0] imem_addr_out;
  logic         imem_ready_in;
  logic [N-1:0] imem_rdata_in;

  modport master (
    output imem_req_out,
    output imem_addr_out,
    input  imem_ready_in,
    input  imem_rdata_in
  );

  modport slave (
    input  imem_req_out,
    input  imem_addr_out,
    output imem_ready_in,
    output imem_rdata_in
  );
endinterface

// File: rtl/if_fetch_stage_skid_slot.sv
// rtl/if_fetch_stage_skid_slot.sv - output slot plus one-deep skid register feeding IF/ID
import if_fetch_stage_pkg::*;

module if_skid_slot #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset_in,
  input  logic         i_flush,
  input  logic         i_consume,
  input  logic         i_fill,
  input  logic         i_skid_load,
  input  logic         i_skid_pop,
  input  logic [N-1:0] i_instr,
  input  logic [N-1:0] i_pc4,
  output logic         o_slot_valid,
  output logic         o_skid_valid,
  output logic [N-1:0] o_instr,
  output logic [N-1:0] o_pc4
);

  logic         r_slot_valid;
  logic [N-1:0] r_slot_instr;
  logic [N-1:0] r_slot_pc4;
  logic         r_skid_valid;
  logic [N-1:0] r_skid_instr;
  logic [N-1:0] r_skid_pc4;

  // Presented slot: redirect kills it, fresh data or the skid entry reloads it, consumption empties it
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      r_slot_valid <= 1'b0;
      r_slot_instr <= '0;
      r_slot_pc4   <= '0;
    end else if (i_flush) begin
      r_slot_valid <= 1'b0;
    end else if (i_fill) begin
      r_slot_valid <= 1'b1;
      r_slot_instr <= i_instr;
      r_slot_pc4   <= i_pc4;
    end else if (i_skid_pop) begin
      r_slot_valid <= r_skid_valid;
      r_slot_instr <= r_skid_instr;
      r_slot_pc4   <= r_skid_pc4;
    end else if (i_consume) begin
      r_slot_valid <= 1'b0;
    end
  end

  // Skid entry catches the word that arrives while the slot is held by a stall
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      r_skid_valid <= 1'b0;
      r_skid_instr <= '0;
      r_skid_pc4   <= '0;
    end else if (i_flush || i_skid_pop) begin
      r_skid_valid <= 1'b0;
    end else if (i_skid_load) begin
      r_skid_valid <= 1'b1;
      r_skid_instr <= i_instr;
      r_skid_pc4   <= i_pc4;
    end
  end

  assign o_slot_valid = r_slot_valid;
  assign o_skid_valid = r_skid_valid;
  assign o_instr      = r_slot_valid ? r_slot_instr : N'(NOP_INSTR);
  assign o_pc4        = r_slot_pc4;

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - MIPS fetch stage: PC ownership, imem handshake FSM, redirects
import if_fetch_stage_pkg::*;

module if_fetch_stage #(
  parameter int           N        = 32,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_in,
  input  logic            enable,
  input  logic            flush_branch,
  input  logic [N-1:0]    Branch_Target_in,
  input  logic            flush_jump,
  input  logic [N-1:0]    Jump_Target_in,
  if_fetch_stage_if.master imem,
  output logic [N-1:0]    PC_Counter_output_out,
  output logic [N-1:0]    Instruction_memory_out,
  output logic            fetch_valid_out
);

  fetch_state_e r_state;
  fetch_state_e w_state_next;
  logic [N-1:0] r_pc_q;
  logic [N-1:0] w_pc_next;
  logic [N-1:0] r_drain_addr;
  logic [N-1:0] w_drain_next;
  logic [N-1:0] w_pc4;
  logic [N-1:0] w_target;
  logic         w_redirect;
  logic         w_xfer;
  logic         w_slot_valid;
  logic         w_skid_valid;
  logic         w_slot_free;
  logic         w_fill;
  logic         w_skid_load;
  logic         w_skid_pop;

  // Branch takes priority over jump; targets are always word aligned
  assign w_redirect  = flush_branch | flush_jump;
  assign w_target    = (flush_branch ? Branch_Target_in : Jump_Target_in) & N'(ALIGN_MASK);
  assign w_pc4       = r_pc_q + N'(PC_INCR);
  assign w_xfer      = imem.imem_req_out && imem.imem_ready_in;
  assign w_slot_free = !w_slot_valid || enable;

  // Request and address are decoded from registered state only, so they stay stable until transfer
  assign imem.imem_req_out  = (r_state == ST_REQ) || (r_state == ST_DRAIN);
  assign imem.imem_addr_out = (r_state == ST_DRAIN) ? r_drain_addr :
                              (r_state == ST_REQ)   ? r_pc_q       : '0;

  // State, PC and drain-address registers
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      r_state      <= ST_IDLE;
      r_pc_q       <= RESET_PC;
      r_drain_addr <= '0;
    end else begin
      r_state      <= w_state_next;
      r_pc_q       <= w_pc_next;
      r_drain_addr <= w_drain_next;
    end
  end

  // Next-state, PC update and slot/skid steering
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc_q;
    w_drain_next = r_drain_addr;
    w_fill       = 1'b0;
    w_skid_load  = 1'b0;
    w_skid_pop   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_state_next = ST_REQ;
        if (w_redirect) w_pc_next = w_target;
      end
      ST_REQ: begin
        if (w_xfer) begin
          if (w_redirect) begin
            w_pc_next = w_target;
          end else if (w_slot_free) begin
            w_fill    = 1'b1;
            w_pc_next = w_pc4;
          end else begin
            w_skid_load  = 1'b1;
            w_pc_next    = w_pc4;
            w_state_next = ST_HOLD;
          end
        end else if (w_redirect) begin
          // The outstanding request must complete at its old address before the target is fetched
          w_drain_next = r_pc_q;
          w_pc_next    = w_target;
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_redirect) w_pc_next = w_target;
        if (w_xfer) w_state_next = ST_REQ;
      end
      ST_HOLD: begin
        if (w_redirect) begin
          w_pc_next    = w_target;
          w_state_next = ST_REQ;
        end else if (enable) begin
          w_skid_pop   = w_skid_valid;
          w_state_next = ST_REQ;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  if_skid_slot #(.N(N)) u_slot (
    .clk          (clk),
    .reset_in     (reset_in),
    .i_flush      (w_redirect),
    .i_consume    (enable),
    .i_fill       (w_fill),
    .i_skid_load  (w_skid_load),
    .i_skid_pop   (w_skid_pop),
    .i_instr      (imem.imem_rdata_in),
    .i_pc4        (w_pc4),
    .o_slot_valid (w_slot_valid),
    .o_skid_valid (w_skid_valid),
    .o_instr      (Instruction_memory_out),
    .o_pc4        (PC_Counter_output_out)
  );

  assign fetch_valid_out = w_slot_valid;

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - scoreboard bench for if_fetch_stage against a program-order model
module tb_if_fetch_stage;

  logic        clk;
  logic        reset_in;
  logic        enable;
  logic        flush_branch;
  logic [31:0] Branch_Target_in;
  logic        flush_jump;
  logic [31:0] Jump_Target_in;
  logic [31:0] PC_Counter_output_out;
  logic [31:0] Instruction_memory_out;
  logic        fetch_valid_out;

  if_fetch_stage_if #(.N(32)) imem ();

  if_fetch_stage #(.N(32), .RESET_PC(32'h0)) dut (
    .clk                    (clk),
    .reset_in               (reset_in),
    .enable                 (enable),
    .flush_branch           (flush_branch),
    .Branch_Target_in       (Branch_Target_in),
    .flush_jump             (flush_jump),
    .Jump_Target_in         (Jump_Target_in),
    .imem                   (imem),
    .PC_Counter_output_out  (PC_Counter_output_out),
    .Instruction_memory_out (Instruction_memory_out),
    .fetch_valid_out        (fetch_valid_out)
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1;
  endfunction

  assign imem.imem_rdata_in = imem.imem_ready_in ? mem_f(imem.imem_addr_out) : 32'hDEAD_BEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int          n_pass;
  int          n_total;
  bit          mon_on;
  logic [31:0] cur;
  logic [31:0] redir_q[$];
  logic        r_fb, r_fj;
  logic [31:0] r_bt, r_jt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    flush_branch = 1'b0;
    flush_jump   = 1'b0;
  endtask

  task automatic set_redirect(input logic fb, input logic [31:0] bt,
                              input logic fj, input logic [31:0] jt);
    flush_branch     = fb;
    Branch_Target_in = bt;
    flush_jump       = fj;
    Jump_Target_in   = jt;
    if (fb || fj) redir_q.push_back((fb ? bt : jt) & 32'hFFFF_FFFC);
  endtask

  function automatic logic [31:0] rand_target();
    if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
    return $urandom & 32'h0000_0FFF;
  endfunction

  // Monitor: consumed instructions must follow program order from the latest redirect target
  task automatic run_monitor();
    logic        p_live, p_req, p_ready;
    logic [31:0] p_addr;
    p_live = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_on) begin
        p_live = 1'b0;
        continue;
      end
      if (p_live && p_req && !p_ready) begin
        chk("req_hold", 32'(imem.imem_req_out), 32'd1);
        chk("addr_hold", imem.imem_addr_out, p_addr);
      end
      if (!fetch_valid_out) begin
        chk("nop_when_invalid", Instruction_memory_out, 32'h0);
      end else if (enable) begin
        chk("stream_instr", Instruction_memory_out, mem_f(cur));
        chk("stream_pc4", PC_Counter_output_out, cur + 32'd4);
        cur = cur + 32'd4;
      end
      if (flush_branch || flush_jump) begin
        chk("redir_queued", 32'(redir_q.size() > 0), 32'd1);
        if (redir_q.size() > 0) cur = redir_q.pop_front();
      end
      p_live  = 1'b1;
      p_req   = imem.imem_req_out;
      p_ready = imem.imem_ready_in;
      p_addr  = imem.imem_addr_out;
    end
  endtask

  task automatic chk_out(input string nm, input logic req, input logic [31:0] addr,
                         input logic vld, input logic [31:0] ins, input logic [31:0] pc4);
    chk({nm, "_req"},   32'(imem.imem_req_out), 32'(req));
    chk({nm, "_addr"},  imem.imem_addr_out, addr);
    chk({nm, "_valid"}, 32'(fetch_valid_out), 32'(vld));
    chk({nm, "_instr"}, Instruction_memory_out, ins);
    chk({nm, "_pc4"},   PC_Counter_output_out, pc4);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    mon_on = 1'b0;
    cur = 32'h0;
    reset_in = 1'b0;
    enable = 1'b1;
    flush_branch = 1'b0;
    flush_jump = 1'b0;
    Branch_Target_in = 32'h0;
    Jump_Target_in = 32'h0;
    imem.imem_ready_in = 1'b1;
    fork
      run_monitor();
    join_none

    tick();
    tick();
    chk_out("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    reset_in = 1'b1;
    cur = 32'h0;
    redir_q.delete();
    mon_on = 1'b1;

    // First request, one-cycle latency, back-to-back delivery
    tick();
    chk("first_req", 32'(imem.imem_req_out), 32'd1);
    chk("first_addr", imem.imem_addr_out, 32'h0);
    tick();
    chk_out("lat1", 1'b1, 32'h4, 1'b1, mem_f(32'h0), 32'h4);
    tick();
    chk("addr8", imem.imem_addr_out, 32'h8);
    chk("instr4", Instruction_memory_out, mem_f(32'h4));

    // Memory stall on address 8
    imem.imem_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("stall", 1'b1, 32'h8, 1'b0, 32'h0, 32'h8);
    end
    imem.imem_ready_in = 1'b1;
    tick();
    chk("stall_done_instr", Instruction_memory_out, mem_f(32'h8));
    chk("stall_done_pc4", PC_Counter_output_out, 32'hC);

    // Downstream stall: slot and skid fill, request drops
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_req", 32'(imem.imem_req_out), 32'd0);
      chk("hold_instr", Instruction_memory_out, mem_f(32'h8));
    end
    enable = 1'b1;
    tick();
    chk("skid_instr", Instruction_memory_out, mem_f(32'hC));
    chk("skid_addr", imem.imem_addr_out, 32'h10);
    tick();
    chk("after_skid_instr", Instruction_memory_out, mem_f(32'h10));

    // Branch and jump together: branch wins
    set_redirect(1'b1, 32'h40, 1'b1, 32'h80);
    tick();
    chk_out("bj", 1'b1, 32'h40, 1'b0, 32'h0, 32'h14);
    tick();
    chk("bj_instr", Instruction_memory_out, mem_f(32'h40));
    chk("bj_pc4", PC_Counter_output_out, 32'h44);

    // Redirect while 0x20 is outstanding: drain, then fetch the target
    set_redirect(1'b0, 32'h0, 1'b1, 32'h20);
    tick();
    chk("jmp_addr", imem.imem_addr_out, 32'h20);
    imem.imem_ready_in = 1'b0;
    tick();
    chk("wait20_addr", imem.imem_addr_out, 32'h20);
    set_redirect(1'b1, 32'h100, 1'b0, 32'h0);
    tick();
    chk_out("drain", 1'b1, 32'h20, 1'b0, 32'h0, 32'h44);
    tick();
    chk("drain_addr2", imem.imem_addr_out, 32'h20);
    imem.imem_ready_in = 1'b1;
    tick();
    chk_out("post_drain", 1'b1, 32'h100, 1'b0, 32'h0, 32'h44);
    tick();
    chk("tgt_instr", Instruction_memory_out, mem_f(32'h100));
    chk("tgt_pc4", PC_Counter_output_out, 32'h104);

    // Asynchronous reset in the middle of a drain
    imem.imem_ready_in = 1'b0;
    set_redirect(1'b0, 32'h0, 1'b1, 32'h200);
    tick();
    chk("pre_rst_drain_addr", imem.imem_addr_out, 32'h104);
    mon_on = 1'b0;
    #2;
    reset_in = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    reset_in = 1'b1;
    imem.imem_ready_in = 1'b1;
    cur = 32'h0;
    redir_q.delete();
    mon_on = 1'b1;
    tick();
    chk("restart_req", 32'(imem.imem_req_out), 32'd1);
    chk("restart_addr", imem.imem_addr_out, 32'h0);

    // Unaligned target is masked; PC wraps past the top of the address space
    set_redirect(1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0);
    tick();
    chk("mask_addr", imem.imem_addr_out, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc4", PC_Counter_output_out, 32'h0);
    chk("wrap_addr", imem.imem_addr_out, 32'h0);

    // Randomized traffic: memory waits, downstream stalls, redirects
    for (int c = 0; c < 3000; c++) begin
      imem.imem_ready_in = ($urandom_range(0, 3) != 0);
      enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        r_fb = 1'($urandom_range(0, 1));
        r_fj = r_fb ? 1'($urandom_range(0, 1)) : 1'b1;
        r_bt = rand_target();
        r_jt = rand_target();
        set_redirect(r_fb, r_bt, r_fj, r_jt);
      end
      tick();
    end
    imem.imem_ready_in = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("redir_q_drained", 32'(redir_q.size()), 32'd0);
    mon_on = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
